// File: rtl/tile_fetch.sv
// tile_fetch: walks one input tile window element by element in row-major
// order and issues one feature-map element address per handshake.
// Coordinates outside the image are flagged as padding, and the consumer
// substitutes zero for them.
//
// Parameters
//   DIM_W   width of dimension, count and coordinate fields
//   ADDR_W  width of element addresses
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cfg_img_h/w, cfg_base/pitch  image geometry, captured when a tile starts
//   desc_valid/ready             tile descriptor handshake (ready only in IDLE)
//   desc_in_row/col              signed top-left input coordinate
//   desc_in_h/w                  window size; a zero size is completed at once
//   pix_valid/ready              element request handshake
//   pix_addr, pix_pad, pix_last  element address (0 when padded), pad flag,
//                                last element of tile
//   tile_done                    one-cycle pulse when a tile completes
//   busy                         a tile is in progress
//   stat_pix_cnt, stat_pad_cnt   element / padded element counters
//
// Optional feature: define TILE_FETCH_STATS_EN to build the statistics
// counters. Without it, both counter ports read 0.
module tile_fetch #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIM_W-1:0]        cfg_img_h,
  input  logic [DIM_W-1:0]        cfg_img_w,
  input  logic [ADDR_W-1:0]       cfg_base,
  input  logic [ADDR_W-1:0]       cfg_pitch,
  input  logic                    desc_valid,
  output logic                    desc_ready,
  input  logic signed [DIM_W:0]   desc_in_row,
  input  logic signed [DIM_W:0]   desc_in_col,
  input  logic [DIM_W-1:0]        desc_in_h,
  input  logic [DIM_W-1:0]        desc_in_w,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [ADDR_W-1:0]       pix_addr,
  output logic                    pix_pad,
  output logic                    pix_last,
  output logic                    tile_done,
  output logic                    busy,
  output logic [31:0]             stat_pix_cnt,
  output logic [31:0]             stat_pad_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [DIM_W-1:0] DIM_ONE = {{(DIM_W-1){1'b0}}, 1'b1};

  // Image coordinate of a window element. Two extra bits over DIM_W cover the
  // full signed origin range plus the largest in-window offset without overflow.
  function automatic logic signed [DIM_W+1:0] coord(
    input logic signed [DIM_W:0] org,
    input logic [DIM_W-1:0]      idx
  );
    logic signed [DIM_W+1:0] org_x;
    logic signed [DIM_W+1:0] idx_x;
    org_x = {org[DIM_W], org};
    idx_x = $signed({2'b00, idx});
    coord = org_x + idx_x;
  endfunction

  // Control state
  logic [0:0]       state_q;
  logic [DIM_W-1:0] r_q;
  logic [DIM_W-1:0] c_q;
  logic             tile_done_q;

  // Tile geometry captured at descriptor acceptance (data path, no reset)
  logic signed [DIM_W:0] row_q;
  logic signed [DIM_W:0] col_q;
  logic [DIM_W-1:0]      h_q;
  logic [DIM_W-1:0]      w_q;
  logic [DIM_W-1:0]      img_h_q;
  logic [DIM_W-1:0]      img_w_q;
  logic [ADDR_W-1:0]     base_q;
  logic [ADDR_W-1:0]     pitch_q;

  logic run;
  logic accept;
  logic desc_nonempty;
  logic adv;
  logic col_end;
  logic row_end;

  assign run           = (state_q == RUN);
  assign accept        = desc_valid && (state_q == IDLE);
  assign desc_nonempty = (desc_in_h != '0) && (desc_in_w != '0);
  assign adv           = run && pix_ready;
  assign col_end       = (c_q == w_q - DIM_ONE);
  assign row_end       = (r_q == h_q - DIM_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          if (desc_nonempty) begin
            state_q <= RUN;
            r_q     <= '0;
            c_q     <= '0;
          end else begin
            // Empty window: nothing to emit, report completion right away.
            tile_done_q <= 1'b1;
          end
        end
      end else if (adv) begin
        if (col_end) begin
          c_q <= '0;
          if (row_end) begin
            state_q     <= IDLE;
            r_q         <= '0;
            tile_done_q <= 1'b1;
          end else begin
            r_q <= r_q + DIM_ONE;
          end
        end else begin
          c_q <= c_q + DIM_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && desc_nonempty) begin
      row_q   <= desc_in_row;
      col_q   <= desc_in_col;
      h_q     <= desc_in_h;
      w_q     <= desc_in_w;
      img_h_q <= cfg_img_h;
      img_w_q <= cfg_img_w;
      base_q  <= cfg_base;
      pitch_q <= cfg_pitch;
    end
  end

  // Element address stage: combinational from registered state only
  logic signed [DIM_W+1:0] y;
  logic signed [DIM_W+1:0] x;
  logic                    pad;
  logic [ADDR_W-1:0]       y_a;
  logic [ADDR_W-1:0]       x_a;
  logic [ADDR_W-1:0]       elem_addr;

  assign y   = coord(row_q, r_q);
  assign x   = coord(col_q, c_q);
  assign pad = y[DIM_W+1] || x[DIM_W+1] ||
               (y >= $signed({2'b00, img_h_q})) ||
               (x >= $signed({2'b00, img_w_q}));
  // Only meaningful when not padded, where y and x are non-negative.
  assign y_a       = ADDR_W'(y[DIM_W:0]);
  assign x_a       = ADDR_W'(x[DIM_W:0]);
  assign elem_addr = base_q + y_a * pitch_q + x_a;

  assign desc_ready = (state_q == IDLE);
  assign busy       = run;
  assign pix_valid  = run;
  assign pix_pad    = run && pad;
  assign pix_addr   = (run && !pad) ? elem_addr : '0;
  assign pix_last   = run && col_end && row_end;
  assign tile_done  = tile_done_q;

`ifdef TILE_FETCH_STATS_EN
  logic [31:0] stat_pix_q;
  logic [31:0] stat_pad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pix_q <= '0;
      stat_pad_q <= '0;
    end else if (adv) begin
      stat_pix_q <= stat_pix_q + 32'd1;
      if (pad) begin
        stat_pad_q <= stat_pad_q + 32'd1;
      end
    end
  end

  assign stat_pix_cnt = stat_pix_q;
  assign stat_pad_cnt = stat_pad_q;
`else
  assign stat_pix_cnt = '0;
  assign stat_pad_cnt = '0;
`endif

endmodule

// File: tb/tb_tile_fetch.sv
// Directed bench for tile_fetch: 4x4 image at base 0x100, pitch 4.
module tb_tile_fetch;

  logic               clk;
  logic               rst_n;
  logic [15:0]        cfg_img_h;
  logic [15:0]        cfg_img_w;
  logic [31:0]        cfg_base;
  logic [31:0]        cfg_pitch;
  logic               desc_valid;
  logic               desc_ready;
  logic signed [16:0] desc_in_row;
  logic signed [16:0] desc_in_col;
  logic [15:0]        desc_in_h;
  logic [15:0]        desc_in_w;
  logic               pix_valid;
  logic               pix_ready;
  logic [31:0]        pix_addr;
  logic               pix_pad;
  logic               pix_last;
  logic               tile_done;
  logic               busy;
  logic [31:0]        stat_pix_cnt;
  logic [31:0]        stat_pad_cnt;

  int n_total;
  int n_bad;

  // Hand-computed element tables, row-major.
  // Tile (-1,-1,3,3): y,x in -1..1
  logic [31:0] exp_a_addr [9];
  logic        exp_a_pad  [9];
  // Tile (2,2,3,3): y,x in 2..4
  logic [31:0] exp_b_addr [9];
  logic        exp_b_pad  [9];

  tile_fetch #(.DIM_W(16), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_img_h    (cfg_img_h),
    .cfg_img_w    (cfg_img_w),
    .cfg_base     (cfg_base),
    .cfg_pitch    (cfg_pitch),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_in_row  (desc_in_row),
    .desc_in_col  (desc_in_col),
    .desc_in_h    (desc_in_h),
    .desc_in_w    (desc_in_w),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_addr     (pix_addr),
    .pix_pad      (pix_pad),
    .pix_last     (pix_last),
    .tile_done    (tile_done),
    .busy         (busy),
    .stat_pix_cnt (stat_pix_cnt),
    .stat_pad_cnt (stat_pad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start a 3x3 tile at (row,col) and walk it. Called just after a negedge.
  // sel picks the expected table; stall_el/stall_cyc hold pix_ready low for
  // stall_cyc cycles while element stall_el is presented (-1: no stall).
  task automatic run_tile(input logic signed [16:0] row, input logic signed [16:0] col,
                          input int sel, input int stall_el, input int stall_cyc,
                          input string name);
    logic [31:0] ea;
    logic        ep;
    cfg_base    = 32'h100;
    desc_in_row = row;
    desc_in_col = col;
    desc_in_h   = 16'd3;
    desc_in_w   = 16'd3;
    desc_valid  = 1'b1;
    pix_ready   = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
    // Configuration changes during the tile must not affect it.
    cfg_base   = 32'h900;
    chk({name, "_busy"}, busy, 1'b1);
    chk({name, "_dready"}, desc_ready, 1'b0);
    for (int i = 0; i < 9; i++) begin
      ea = (sel == 0) ? exp_a_addr[i] : exp_b_addr[i];
      ep = (sel == 0) ? exp_a_pad[i]  : exp_b_pad[i];
      chk($sformatf("%s_vld%0d", name, i), pix_valid, 1'b1);
      chk($sformatf("%s_addr%0d", name, i), pix_addr, ea);
      chk($sformatf("%s_pad%0d", name, i), pix_pad, ep);
      chk($sformatf("%s_last%0d", name, i), pix_last, (i == 8));
      chk($sformatf("%s_done%0d", name, i), tile_done, 1'b0);
      if (i == stall_el) begin
        pix_ready = 1'b0;
        for (int k = 0; k < stall_cyc; k++) begin
          @(negedge clk);
          chk($sformatf("%s_hold_addr%0d", name, k), pix_addr, ea);
          chk($sformatf("%s_hold_pad%0d", name, k), pix_pad, ep);
          chk($sformatf("%s_hold_last%0d", name, k), pix_last, 1'b0);
          chk($sformatf("%s_hold_vld%0d", name, k), pix_valid, 1'b1);
        end
        pix_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk({name, "_end_done"}, tile_done, 1'b1);
    chk({name, "_end_vld"}, pix_valid, 1'b0);
    chk({name, "_end_dready"}, desc_ready, 1'b1);
    @(negedge clk);
    chk({name, "_done_pulse"}, tile_done, 1'b0);
    cfg_base = 32'h100;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    exp_a_addr = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h100, 32'h101, 32'h0, 32'h104, 32'h105};
    exp_a_pad  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_b_addr = '{32'h10A, 32'h10B, 32'h0, 32'h10E, 32'h10F, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_b_pad  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n       = 1'b0;
    cfg_img_h   = 16'd4;
    cfg_img_w   = 16'd4;
    cfg_base    = 32'h100;
    cfg_pitch   = 32'd4;
    desc_valid  = 1'b0;
    desc_in_row = 17'sd0;
    desc_in_col = 17'sd0;
    desc_in_h   = 16'd0;
    desc_in_w   = 16'd0;
    pix_ready   = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_vld", pix_valid, 1'b0);
    chk("rst_dready", desc_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tile_done, 1'b0);
    chk("rst_addr", pix_addr, 32'h0);
    chk("rst_pad", pix_pad, 1'b0);
    chk("rst_last", pix_last, 1'b0);
    chk("rst_spix", stat_pix_cnt, 32'd0);
    chk("rst_spad", stat_pad_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Padded corner tile, free-running.
    run_tile(-17'sd1, -17'sd1, 0, -1, 0, "t034");
`ifdef TILE_FETCH_STATS_EN
    chk("stat_pix", stat_pix_cnt, 32'd9);
    chk("stat_pad", stat_pad_cnt, 32'd5);
`else
    chk("stat_pix", stat_pix_cnt, 32'd0);
    chk("stat_pad", stat_pad_cnt, 32'd0);
`endif

    // Same tile with a 3-cycle stall on element 4.
    run_tile(-17'sd1, -17'sd1, 0, 3, 3, "t035");

    // Tile hanging off the bottom-right edge.
    run_tile(17'sd2, 17'sd2, 1, -1, 0, "t036");

    // Empty descriptor.
    desc_in_row = 17'sd0;
    desc_in_col = 17'sd0;
    desc_in_h   = 16'd0;
    desc_in_w   = 16'd3;
    desc_valid  = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
    chk("t037_vld", pix_valid, 1'b0);
    chk("t037_done", tile_done, 1'b1);
    chk("t037_dready", desc_ready, 1'b1);
    @(negedge clk);
    chk("t037_done_pulse", tile_done, 1'b0);
    chk("t037_vld2", pix_valid, 1'b0);

    // Reset in the middle of a tile after 4 elements.
    desc_in_row = -17'sd1;
    desc_in_col = -17'sd1;
    desc_in_h   = 16'd3;
    desc_in_w   = 16'd3;
    desc_valid  = 1'b1;
    pix_ready   = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t038_elem4_addr", pix_addr, 32'h100);
    rst_n = 1'b0;
    #1;
    chk("t038_vld", pix_valid, 1'b0);
    chk("t038_busy", busy, 1'b0);
    chk("t038_done", tile_done, 1'b0);
    chk("t038_spix", stat_pix_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t038_dready", desc_ready, 1'b1);
    chk("t038_done2", tile_done, 1'b0);
    run_tile(-17'sd1, -17'sd1, 0, -1, 0, "t038b");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_fetch.md
TILE_FETCH -- requirements
Module: tile_fetch

Interface
REQ-001 Parameter DIM_W, default 16, width of dimension, count and coordinate fields.
REQ-002 Parameter ADDR_W, default 32, width of feature-map element addresses.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 cfg_img_h, cfg_img_w  input  DIM_W each  input image height and width in elements; quasi-static.
REQ-006 cfg_base  input  ADDR_W  address of image element (0,0).
REQ-007 cfg_pitch  input  ADDR_W  address step per image row.
REQ-008 desc_valid / desc_ready  input / output  1 each  tile descriptor handshake.
REQ-009 desc_in_row, desc_in_col  input  DIM_W+1 signed each  top-left input coordinate, negative when padded.
REQ-010 desc_in_h, desc_in_w  input  DIM_W each  input window height and width.
REQ-011 pix_valid / pix_ready  output / input  1 each  element request handshake.
REQ-012 pix_addr  output  ADDR_W  element address; 0 when pix_pad=1.
REQ-013 pix_pad  output  1  element lies outside the image; consumer substitutes zero.
REQ-014 pix_last  output  1  final element of the current tile.
REQ-015 tile_done  output  1  one-cycle pulse at tile completion.
REQ-016 busy  output  1  high in RUN.
REQ-017 stat_pix_cnt, stat_pad_cnt  output  32 each  statistics counters (see Configuration).

Function
REQ-018 FSM states: IDLE, RUN; desc_ready=1 exactly in IDLE; busy=1 exactly in RUN.
REQ-019 IDLE, descriptor handshake with desc_in_h>0 and desc_in_w>0: latch descriptor and all cfg_* inputs, set r=0, c=0, go to RUN.
REQ-020 IDLE, descriptor handshake with desc_in_h=0 or desc_in_w=0: no elements emitted, stay IDLE, tile_done=1 on the following cycle.
REQ-021 RUN: pix_valid=1; outputs are a function of registered state only (no combinational path from pix_ready).
REQ-022 Element (r,c): y=in_row+r, x=in_col+c, computed signed with DIM_W+2 bits, no overflow.
REQ-023 pix_pad=1 when y<0, x<0, y>=img_h or x>=img_w; otherwise pix_addr=(base+y*pitch+x) mod 2^ADDR_W.
REQ-024 Order row-major: c increments; at c=in_w-1, c wraps to 0 and r increments.
REQ-025 pix_last=1 when r=in_h-1 and c=in_w-1.
REQ-026 Element advances only on pix_valid and pix_ready; with pix_ready=0 all pix_* outputs hold stable.
REQ-027 Handshake on pix_last: go to IDLE next cycle and pulse tile_done that cycle; desc_ready rises the same cycle (one-cycle bubble between tiles).
REQ-028 Throughput in RUN with pix_ready held high: one element per cycle; tile of H*W elements emits in H*W cycles.
REQ-029 desc_valid is ignored in RUN; cfg_* changes in RUN do not affect the active tile.

Reset
REQ-030 rst_n low: state IDLE; pix_valid, pix_last, pix_pad, tile_done, busy =0; pix_addr=0; r, c =0; desc_ready=1; statistics counters =0.
REQ-031 Reset in RUN abandons the tile immediately with no tile_done; the next accepted descriptor starts at (0,0).

Configuration
REQ-032 Macro TILE_FETCH_STATS_EN defined: stat_pix_cnt increments on every pix handshake; stat_pad_cnt increments on pix handshakes with pix_pad=1; both wrap at 2^32 and clear only on reset.
REQ-033 Macro TILE_FETCH_STATS_EN undefined: both ports present, tied to 0, no counter logic.

Verification
REQ-034 img 4x4, base 0x100, pitch 4, desc (-1,-1,3,3), pix_ready=1 -> 9 elements; 5 with pad=1 and addr 0; element (1,1) addr 0x100; element (2,2) addr 0x105; pix_last on element 9; tile_done on the next cycle.
REQ-035 Same tile, pix_ready low for 3 cycles at element 4 -> outputs frozen; elements 4-9 each appear exactly once, in order.
REQ-036 img 4x4, base 0x100, pitch 4, desc (2,2,3,3) -> element (0,0) addr 0x10A; elements with y=4 or x=4 have pad=1 (5 total).
REQ-037 desc_in_h=0 -> descriptor accepted, pix_valid stays 0, tile_done one cycle after acceptance, desc_ready stays 1.
REQ-038 rst_n asserted after 4 elements -> pix_valid=0 immediately; after release desc_ready=1; next tile's first element is (0,0).
REQ-039 TILE_FETCH_STATS_EN defined, after REQ-034 -> stat_pix_cnt=9, stat_pad_cnt=5; macro undefined -> both 0.
